// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-clock FIFO controller that drives an external
// dual-port ram with a registered read port.
//
// This controller owns the pointers, the occupancy count, the status flags
// and the read-data-valid timing.
//
// Optional feature macro: RAM_FIFO_ERR_EN
//   When defined, the module adds the sticky o_overflow and o_underflow flags.
//   It also adds the i_err_clr input that clears them.
//   When undefined, rejected requests are silently dropped.

package ram_fifo_ctrl_pkg;
  // Number of bits needed to represent value. This is the same sizing rule
  // the ram uses. With an argument of DATA_DEPTH-1 it gives the address width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 64,
  parameter int AF_MARGIN  = 4,
  parameter int AE_MARGIN  = 4,
  localparam int AW        = clog2(DATA_DEPTH - 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rdata_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [AW:0]           o_count,
  output logic                  o_ram_wren,
  output logic [AW-1:0]         o_ram_waddr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_rden,
  output logic [AW-1:0]         o_ram_raddr,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
`ifdef RAM_FIFO_ERR_EN
  ,
  input  logic                  i_err_clr,
  output logic                  o_overflow,
  output logic                  o_underflow
`endif
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DATA_DEPTH);
  localparam logic [AW:0] AF_LEVEL   = (AW+1)'(DATA_DEPTH - AF_MARGIN);
  localparam logic [AW:0] AE_LEVEL   = (AW+1)'(AE_MARGIN);

  // Pointers carry one extra wrap bit above the ram address.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] r_count;
  logic        r_empty;
  logic        r_full;
  logic        r_almost_full;
  logic        r_almost_empty;
  logic        r_rdata_valid;

  logic        w_wr_acc;
  logic        w_rd_acc;
  logic [AW:0] w_count_next;

  // Accept terms: requests against a full/empty FIFO are dropped.
  assign w_wr_acc = i_wr_en & ~r_full;
  assign w_rd_acc = i_rd_en & ~r_empty;

  // Occupancy after this edge; an accepted write and read together cancel out.
  assign w_count_next = r_count + {{AW{1'b0}}, w_wr_acc} - {{AW{1'b0}}, w_rd_acc};

  // Pointer, count and flag registers; the flags are taken from the next count
  // so they change on the same edge as the pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_rdata_valid  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == FULL_LEVEL);
      r_almost_full  <= (w_count_next >= AF_LEVEL);
      r_almost_empty <= (w_count_next <= AE_LEVEL);
      // The ram registers its read, so the data lands one cycle after rd_acc.
      r_rdata_valid  <= w_rd_acc;
    end
  end

  // The ram ports are driven straight from the accept terms and the pointers.
  assign o_ram_wren  = w_wr_acc;
  assign o_ram_waddr = r_wptr[AW-1:0];
  assign o_ram_wdata = i_wdata;
  assign o_ram_rden  = w_rd_acc;
  assign o_ram_raddr = r_rptr[AW-1:0];

  assign o_rdata        = i_ram_rdata;
  assign o_rdata_valid  = r_rdata_valid;
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_count        = r_count;

  // The count-derived flags must agree with the pointer relations.
  // The wrap bit separates "full" from "empty" when the addresses match.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_empty == (r_wptr == r_rptr));
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_full == ((r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW])));

`ifdef RAM_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr_en & r_full) begin
        r_overflow <= 1'b1;
      end else if (i_err_clr) begin
        r_overflow <= 1'b0;
      end
      if (i_rd_en & r_empty) begin
        r_underflow <= 1'b1;
      end else if (i_err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the team's dual-port ram block as a synchronous FIFO. It owns the write and read pointers, the occupancy count, the status flags and read-data-valid timing. The controller drives the ram write and read ports directly, with both ram clock inputs tied to i_clk. It sits between a producer/consumer pair and one ram instance of matching DATA_WIDTH/DATA_DEPTH.

Parameters:
DATA_WIDTH, 8, word width; must match the attached ram.
DATA_DEPTH, 64, number of entries; power of two, >= 4; must match the ram.
AF_MARGIN, 4, o_almost_full asserts when count >= DATA_DEPTH - AF_MARGIN.
AE_MARGIN, 4, o_almost_empty asserts when count <= AE_MARGIN.
Derived: AW = clog2(DATA_DEPTH-1), the address width, computed with the same local clog2 function as the ram.

Ports:
i_clk  in  1  single clock; also feeds the ram i_wrclk and i_rdclk.
i_rst_n  in  1  asynchronous, active-low reset; also feeds the ram i_wrst_n and i_rdrst_n.
i_wr_en  in  1  producer write request.
i_wdata  in  DATA_WIDTH  producer write data.
i_rd_en  in  1  consumer read request.
o_rdata  out  DATA_WIDTH  read data; equals i_ram_rdata.
o_rdata_valid  out  1  o_rdata holds a popped word.
o_full  out  1  FIFO full.
o_empty  out  1  FIFO empty.
o_almost_full  out  1  count >= DATA_DEPTH - AF_MARGIN.
o_almost_empty  out  1  count <= AE_MARGIN.
o_count  out  AW+1  occupancy, 0..DATA_DEPTH.
o_ram_wren  out  1  to ram i_wren.
o_ram_waddr  out  AW  to ram i_waddr.
o_ram_wdata  out  DATA_WIDTH  to ram i_wdata.
o_ram_rden  out  1  to ram i_rden.
o_ram_raddr  out  AW  to ram i_raddr.
i_ram_rdata  in  DATA_WIDTH  from ram o_rdata.

Behaviour:
- Reset (async assert, sync release):
  - wptr = rptr = 0; both are AW+1 bits (the MSB is the wrap bit).
  - o_count = 0, o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0, o_rdata_valid = 0.
- Accept terms:
  - wr_acc = i_wr_en & ~o_full.
  - rd_acc = i_rd_en & ~o_empty.
  - Rejected requests have no effect on any state.
- RAM port drive (combinational):
  - o_ram_wren = wr_acc, o_ram_waddr = wptr[AW-1:0], o_ram_wdata = i_wdata.
  - o_ram_rden = rd_acc, o_ram_raddr = rptr[AW-1:0].
- Pointers:
  - On wr_acc, wptr increments by 1; on rd_acc, rptr increments by 1.
  - Both wrap naturally modulo 2*DATA_DEPTH.
- Count: next = count + wr_acc - rd_acc. If both are accepted in the same cycle, count is unchanged.
- Flags are registered and updated on the same edge as the pointers, computed from next count:
  - o_empty = (next == 0); o_full = (next == DATA_DEPTH).
  - The almost flags use the same next count.
  - The flags must equal the pointer relations: empty when wptr == rptr; full when the addresses match and the wrap bits differ.
- Read latency:
  - The ram registers its read, so o_rdata_valid is asserted for exactly the one cycle after rd_acc.
  - o_rdata = i_ram_rdata; the ram holds the word until the next rden.
- Full with simultaneous rd/wr: the write is rejected (no pass-through); the read proceeds. Count goes to DATA_DEPTH-1.
- Empty with simultaneous rd/wr: the read is rejected and the write proceeds. No fall-through: the word is readable from the following cycle.
- Reset mid-operation: all state returns to reset values immediately. The ram contents are cleared by the shared reset; in-flight o_rdata_valid drops.

Optional Feature:
Macro RAM_FIFO_ERR_EN.
- Defined: adds outputs o_overflow and o_underflow (1 bit each), plus input i_err_clr.
  - o_overflow is set when i_wr_en & o_full; o_underflow is set when i_rd_en & o_empty.
  - Both flags are sticky until i_err_clr is high on a clock edge. If set and clear coincide, set wins.
  - Both reset to 0.
- Undefined: the ports and logic are absent, and rejected requests are silently dropped.

Test Plan:
1. Reset, then idle for 5 cycles -> o_empty=1, o_full=0, o_count=0, o_almost_empty=1, o_rdata_valid=0, o_ram_wren=0, o_ram_rden=0.
2. Write 0x00..0x3F (64 words), then read 64 -> o_full=1 after the 64th write, with o_almost_full from count 60. Reads return 0x00..0x3F in order, each with o_rdata_valid one cycle after its rd_acc. o_empty=1 at the end.
3. At full, assert i_wr_en with 0xAA for 3 cycles -> o_ram_wren=0 and o_count stays 64. With RAM_FIFO_ERR_EN, o_overflow=1 and it is cleared by i_err_clr.
4. Fill to 10, then assert rd and wr together for 200 cycles -> o_count stays 10, pointers wrap past 127 to 0, and data order is preserved.
5. When empty, assert i_rd_en and i_wr_en (0x5A) together -> the read is rejected and o_count=1. A read on the next cycle returns 0x5A with o_rdata_valid.
6. Fill to 20 words, then deassert i_rst_n mid-stream -> all outputs return to reset values asynchronously. After release, the first write/read returns the new data, not stale data.
